// File: rtl/cpu_fetch_queue.sv
// cpu_fetch_queue
//   Instruction fetch front end. Issues one word fetch at a time to a
//   variable-latency instruction memory. Buffers the returned words in a
//   small circular FIFO and presents {pc+4, instruction} to decode under a
//   valid/ready handshake. A redirect flushes the FIFO and any fetch still
//   in flight, then restarts fetching at the new address.
//
// Ports
//   clk, reset           clock; synchronous active-high reset
//   mem_req/mem_addr     fetch request and word-aligned byte address
//   mem_ack/mem_rdata    memory response for the current request
//   redirect/redirect_pc jump taken and its target (low 2 bits ignored)
//   out_valid/out_ready  head-of-queue handshake toward decode
//   out_pc4/out_inst     head entry: instruction address + 4, instruction
//   count                number of queued entries, 0..DEPTH
module cpu_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     mem_req,
    output logic [31:0]              mem_addr,
    input  logic                     mem_ack,
    input  logic [31:0]              mem_rdata,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc4,
    output logic [31:0]              out_inst,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]    state;
    logic [31:0]   fetch_pc;
    logic [31:0]   drop_addr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   pc4_mem  [DEPTH];
    logic [31:0]   inst_mem [DEPTH];

    logic          push;
    logic          pop;
    logic [AW:0]   cnt_next;
    logic [31:0]   redirect_aligned;

    assign redirect_aligned = {redirect_pc[31:2], 2'b00};

    assign mem_req  = (state != S_IDLE);
    // An abandoned request must keep presenting its original address until
    // acked, while fetch_pc already holds the redirect target.
    assign mem_addr = (state == S_DROP) ? drop_addr : fetch_pc;

    assign out_valid = (count != '0);
    assign out_pc4   = pc4_mem[rd_ptr];
    assign out_inst  = inst_mem[rd_ptr];

    // Redirect voids both the push and the pop of its cycle.
    assign push     = (state == S_WAIT) && mem_ack && !redirect;
    assign pop      = out_valid && out_ready && !redirect;
    assign cnt_next = count + (AW+1)'(push) - (AW+1)'(pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            fetch_pc  <= RESET_PC;
            drop_addr <= RESET_PC;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc4_mem[i]  <= '0;
                inst_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                pc4_mem[wr_ptr]  <= fetch_pc + 32'd4;
                inst_mem[wr_ptr] <= mem_rdata;
            end

            if (redirect) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                count <= cnt_next;
            end

            case (state)
                S_IDLE: begin
                    if (redirect)
                        fetch_pc <= redirect_aligned;
                    else if (count < FULL)
                        state <= S_WAIT;
                end
                S_WAIT: begin
                    if (redirect) begin
                        fetch_pc <= redirect_aligned;
                        if (mem_ack) begin
                            state <= S_IDLE;
                        end else begin
                            drop_addr <= fetch_pc;
                            state     <= S_DROP;
                        end
                    end else if (mem_ack) begin
                        fetch_pc <= fetch_pc + 32'd4;
                        // Only keep requesting while the returned word is
                        // guaranteed a free slot.
                        state    <= (cnt_next < FULL) ? S_WAIT : S_IDLE;
                    end
                end
                S_DROP: begin
                    if (redirect)
                        fetch_pc <= redirect_aligned;
                    if (mem_ack)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
